perimetro_producer: RTL



---
 rtl/perimetro_pkg.sv | 8 +
 rtl/perimetro_fifo.sv | 45 ++++
 rtl/perimetro_producer.sv | 81 ++++++++
 3 files changed

// File: rtl/perimetro_pkg.sv
// perimetro_pkg: shared constants and types for the perimeter producer slice.
package perimetro_pkg;
    localparam int W_DEFAULT = 4;
    localparam logic IDLE = 1'b0;
    localparam logic WAIT_ACK = 1'b1;
    typedef logic [2*W_DEFAULT-1:0] pair_t;
    typedef enum logic {S_IDLE = IDLE, S_WAIT_ACK = WAIT_ACK} state_t;
endpackage

// File: rtl/perimetro_fifo.sv
// perimetro_fifo: DEPTH-entry FIFO of {a,b} side pairs with registered full/empty.
module perimetro_fifo #(
    parameter int W = 4,
    parameter int DEPTH = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           push,
    input  logic           pop,
    input  logic [2*W-1:0] din,
    output logic [2*W-1:0] dout,
    output logic           full,
    output logic           empty
);
    localparam int AW = $clog2(DEPTH);
    logic [2*W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0] r_cnt, w_cnt_nxt;
    logic r_full, r_empty, w_push, w_pop;
    // full is judged before the pop, so a push against a full FIFO is lost even if a slot frees up
    assign w_push = push && !r_full;
    assign w_pop = pop && !r_empty;
    assign w_cnt_nxt = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt <= '0;
            r_full <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_cnt <= w_cnt_nxt;
            r_full <= w_cnt_nxt == (AW+1)'(DEPTH);
            r_empty <= w_cnt_nxt == '0;
        end
    end
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end
    assign dout = r_mem[r_rd_ptr];
    assign full = r_full;
    assign empty = r_empty;
endmodule

// File: rtl/perimetro_producer.sv
// perimetro_producer: buffers host side pairs and hands them to the perimeter consumer over _dav/rfd.
// Optional PERIMETRO_PRODUCER_COUNT_EN adds sent_cnt (completed transfers) and drop (refused write pulse).
module perimetro_producer
    import perimetro_pkg::*;
#(
    parameter int W = W_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_a,
    input  logic [W-1:0] wr_b,
    output logic         full,
    output logic         empty,
    input  logic         rfd,
    output logic         _dav,
    output logic [W-1:0] a,
    output logic [W-1:0] b
`ifdef PERIMETRO_PRODUCER_COUNT_EN
    ,
    output logic [7:0]   sent_cnt,
    output logic         drop
`endif
);
    state_t r_state, w_state_nxt;
    logic w_pop, r_dav;
    logic [2*W-1:0] w_head;
    logic [W-1:0] r_a, r_b;
    perimetro_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(wr_en),
        .pop(w_pop),
        .din({wr_a, wr_b}),
        .dout(w_head),
        .full(full),
        .empty(empty)
    );
    always_comb begin
        w_pop = 1'b0;
        w_state_nxt = r_state;
        if (r_state == S_IDLE) begin
            w_pop = rfd && !empty;
            w_state_nxt = w_pop ? S_WAIT_ACK : S_IDLE;
        end else begin
            w_state_nxt = rfd ? S_WAIT_ACK : S_IDLE;
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_dav <= 1'b1;
            r_a <= '0;
            r_b <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dav <= w_state_nxt != S_WAIT_ACK;
            if (w_pop) {r_a, r_b} <= w_head;
        end
    end
    assign _dav = r_dav;
    assign a = r_a;
    assign b = r_b;
`ifdef PERIMETRO_PRODUCER_COUNT_EN
    logic [7:0] r_sent_cnt;
    logic r_drop, w_done;
    assign w_done = (r_state == S_WAIT_ACK) && !rfd;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sent_cnt <= '0;
            r_drop <= 1'b0;
        end else begin
            r_sent_cnt <= r_sent_cnt + 8'(w_done);
            r_drop <= wr_en && full;
        end
    end
    assign sent_cnt = r_sent_cnt;
    assign drop = r_drop;
`endif
endmodule
